// File: rtl/fifo_uart_pkg.sv
// Shared types and width helpers for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_CLK_DIV    = 16;

  // Counter width that stays at least one bit for tiny ranges.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned BAUD_CNT_W = cnt_w(DEF_CLK_DIV);
  localparam int unsigned BIT_CNT_W  = cnt_w(DEF_DATA_WIDTH);

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read port of sync_fifo as seen by its consumer (master) and by the FIFO (slave).
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_WIDTH = fifo_uart_pkg::DEF_DATA_WIDTH
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Clear/enable bit-period counter; bit_tick marks the last clk of each serial bit.
module uart_baud_cnt
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);
  localparam int unsigned CntW = cnt_w(CLK_DIV);

  logic [CntW-1:0] cnt_q;

  assign bit_tick = en && !clr && (cnt_q == CntW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= bit_tick ? '0 : cnt_q + CntW'(1);
    end
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from sync_fifo and sends each as a UART frame: start, data LSB first,
// optional even parity, one stop bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned PARITY_EN  = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);
  localparam int unsigned BitW = cnt_w(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  pop;
  logic                  baud_clr;
  logic                  bit_tick;

  assign baud_clr = (state_q == StIdle) || (state_q == StFetch);

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .en       (!baud_clr),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && !fifo.fifo_empty) begin
          pop     = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        shift_d  = fifo.fifo_rd_data;
        parity_d = ^fifo.fifo_rd_data;
        state_d  = StStart;
      end
      StStart: begin
        if (bit_tick) begin
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (bit_cnt_q == BitW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_tick) state_d = StStop;
      end
      StStop: begin
        if (bit_tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // tx is registered, so it is derived from the state being entered.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  // The strobe is combinational from IDLE, so it must be masked while reset is held.
  assign fifo.fifo_rd_en = pop && !rst;
  assign tx              = tx_q;
  assign busy            = (state_q != StIdle) || fifo.fifo_rd_en;
  assign tx_done         = (state_q == StStop) && bit_tick;
endmodule
